// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer_if
// Description : Sample-in / frame-out bundle between FILTER, frame buffer
//               and FFT core.
// Revision    : 1.0
// ============================================================================
interface fft_frame_buffer_if #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LOG2N-1:0]  out_index;
  logic              out_last;
  logic              overflow;
  logic [15:0]       frame_cnt;

  // Environment side: supplies samples and consumes frames.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_index, out_last, overflow, frame_cnt
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_index, out_last, overflow, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer
// Description : Ping-pong frame capture of FILTER samples, streamed to the FFT
//               core in bit-reversed order with a valid/ready handshake.
// Revision    : 1.0
// ============================================================================
module fft_frame_buffer #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 4
) (
  input  wire               clk,
  input  wire               rst,
  fft_frame_buffer_if.slave bus
);

  localparam int               c_n        = 1 << LOG2N;
  localparam logic [LOG2N-1:0] c_last_ptr = LOG2N'(c_n - 1);

  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_stream = 1'b1;

  logic [DATA_W-1:0] r_mem [2][c_n];

  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [LOG2N-1:0]  r_wr_ptr;
  logic [LOG2N-1:0]  r_rd_ptr;
  logic [1:0]        r_bank_full;
  logic [0:0]        r_state;

  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_out_data;
  logic [LOG2N-1:0]  r_out_index;
  logic              r_overflow;
  logic [15:0]       r_frame_cnt;

  logic              w_wr_accept;
  logic              w_wr_done;
  logic              w_hs;
  logic              w_rd_done;
  logic [LOG2N-1:0]  w_rd_ptr_nxt;
  logic [LOG2N-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rd_word;
  logic [1:0]        w_bank_full_nxt;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

  // The full check uses the pre-edge flags, so a bank freed on this edge
  // does not take this edge's sample.
  assign w_wr_accept  = bus.in_valid & ~r_bank_full[r_wr_bank];
  assign w_wr_done    = w_wr_accept & (r_wr_ptr == c_last_ptr);
  assign w_hs         = (r_state == c_stream) & r_out_valid & bus.out_ready;
  assign w_rd_done    = w_hs & r_out_last;
  assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
  assign w_rd_addr    = (r_state == c_idle) ? bitrev('0) : bitrev(w_rd_ptr_nxt);
  assign w_rd_word    = r_mem[r_rd_bank][w_rd_addr];

  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_done) begin
      w_bank_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_done) begin
      w_bank_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_bank][r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (bus.in_valid && !w_wr_accept) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_wr_done) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_rd_bank   <= 1'b0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (r_bank_full[r_rd_bank]) begin
            r_out_data  <= w_rd_word;
            r_out_index <= bitrev('0);
            r_out_valid <= 1'b1;
            r_out_last  <= (c_n == 1);
            r_rd_ptr    <= '0;
            r_state     <= c_stream;
          end
        end
        c_stream: begin
          if (w_rd_done) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= c_idle;
          end else if (w_hs) begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_out_data  <= w_rd_word;
            r_out_index <= bitrev(w_rd_ptr_nxt);
            r_out_last  <= (w_rd_ptr_nxt == c_last_ptr);
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign bus.overflow  = r_overflow;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
